// File: rtl/pcie_link_ctrl.sv
// PCIe hard-IP reset and link supervisor: filters PERST#, sequences HIP npor,
// supervises link training with timeout/retry and reports link statistics.
module pcie_link_ctrl #(
    parameter int LANES            = 8,
    parameter int DEBOUNCE_CYC     = 1024,
    parameter int NPOR_HOLD_CYC    = 256,
    parameter int LINK_TIMEOUT_CYC = 1 << 20,
    parameter int MAX_RETRY        = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        PCIE_PERST,
    input  logic        HIP_LINK_UP,
    input  logic [4:0]  HIP_LANE_ACT,
    output logic        HIP_NPOR,
    output logic        HIP_PIN_PERST,
    output logic        APP_RST,
    output logic        LINK_OK,
    output logic        WIDTH_OK,
    output logic [3:0]  RETRY_CNT,
    output logic [15:0] LINK_DOWN_CNT,
    output logic [2:0]  STATE
);

    localparam int DEB_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam int TMR_MAX = (NPOR_HOLD_CYC > LINK_TIMEOUT_CYC) ? NPOR_HOLD_CYC : LINK_TIMEOUT_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [DEB_W-1:0] DEB_LAST     = DEB_W'(DEBOUNCE_CYC - 1);
    localparam logic [TMR_W-1:0] NPOR_LAST    = TMR_W'(NPOR_HOLD_CYC - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LINK_TIMEOUT_CYC - 1);
    localparam logic [4:0]       LANES_5      = 5'(LANES);
    localparam logic [3:0]       MAX_RETRY_4  = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_RESET_HOLD = 3'd0,
        ST_NPOR_WAIT  = 3'd1,
        ST_TRAIN      = 3'd2,
        ST_UP         = 3'd3,
        ST_FAIL       = 3'd4
    } state_t;

    // Bit 0 carries PERST#, bit 1 carries link-up.
    logic [1:0] sync_in;
    logic [1:0] sync_meta_reg;
    logic [1:0] sync_reg;
    logic       perst_s;
    logic       lu_s;

    assign sync_in = {HIP_LINK_UP, PCIE_PERST};
    assign perst_s = sync_reg[0];
    assign lu_s    = sync_reg[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            always_ff @(posedge CLK) begin
                if (RST) begin
                    sync_meta_reg[gi] <= 1'b0;
                    sync_reg[gi]      <= 1'b0;
                end else begin
                    sync_meta_reg[gi] <= sync_in[gi];
                    sync_reg[gi]      <= sync_meta_reg[gi];
                end
            end
        end
    endgenerate

    logic             perst_f_reg;
    logic             perst_f_d_reg;
    logic [DEB_W-1:0] deb_cnt_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            perst_f_reg   <= 1'b0;
            perst_f_d_reg <= 1'b0;
            deb_cnt_reg   <= '0;
        end else begin
            perst_f_d_reg <= perst_f_reg;
            if (perst_s != perst_f_reg) begin
                if (deb_cnt_reg == DEB_LAST) begin
                    perst_f_reg <= perst_s;
                    deb_cnt_reg <= '0;
                end else begin
                    deb_cnt_reg <= deb_cnt_reg + 1'b1;
                end
            end else begin
                deb_cnt_reg <= '0;
            end
        end
    end

    state_t           state_reg, state_next;
    logic [TMR_W-1:0] tmr_reg, tmr_next;
    logic [3:0]       retry_reg, retry_next;
    logic [15:0]      ldc_reg, ldc_next;
    logic [4:0]       lane_act_reg;
    logic             npor_reg, npor_next;
    logic             app_rst_reg, app_rst_next;
    logic             link_ok_reg, link_ok_next;
    logic             width_ok_reg, width_ok_next;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= ST_RESET_HOLD;
            tmr_reg      <= '0;
            retry_reg    <= '0;
            ldc_reg      <= '0;
            lane_act_reg <= '0;
            npor_reg     <= 1'b0;
            app_rst_reg  <= 1'b1;
            link_ok_reg  <= 1'b0;
            width_ok_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tmr_reg      <= tmr_next;
            retry_reg    <= retry_next;
            ldc_reg      <= ldc_next;
            lane_act_reg <= HIP_LANE_ACT;
            npor_reg     <= npor_next;
            app_rst_reg  <= app_rst_next;
            link_ok_reg  <= link_ok_next;
            width_ok_reg <= width_ok_next;
        end
    end

    // Filtered PERST# low overrides every other transition. Leaving RESET_HOLD
    // waits one extra cycle so pin_perst is already released at the HIP.
    always_comb begin
        state_next = state_reg;
        tmr_next   = tmr_reg;
        retry_next = retry_reg;
        ldc_next   = ldc_reg;
        if (!perst_f_reg) begin
            state_next = ST_RESET_HOLD;
            tmr_next   = '0;
            retry_next = '0;
        end else begin
            case (state_reg)
                ST_RESET_HOLD: begin
                    if (perst_f_d_reg) begin
                        state_next = ST_NPOR_WAIT;
                        tmr_next   = '0;
                    end
                end
                ST_NPOR_WAIT: begin
                    if (tmr_reg == NPOR_LAST) begin
                        state_next = ST_TRAIN;
                        tmr_next   = '0;
                    end else begin
                        tmr_next = tmr_reg + 1'b1;
                    end
                end
                ST_TRAIN: begin
                    if (lu_s) begin
                        state_next = ST_UP;
                        tmr_next   = '0;
                    end else if (tmr_reg == TIMEOUT_LAST) begin
                        retry_next = retry_reg + 1'b1;
                        tmr_next   = '0;
                        state_next = (retry_next == MAX_RETRY_4) ? ST_FAIL : ST_NPOR_WAIT;
                    end else begin
                        tmr_next = tmr_reg + 1'b1;
                    end
                end
                ST_UP: begin
                    if (!lu_s) begin
                        state_next = ST_TRAIN;
                        tmr_next   = '0;
                        if (ldc_reg != 16'hFFFF) begin
                            ldc_next = ldc_reg + 1'b1;
                        end
                    end
                end
                ST_FAIL: begin
                    state_next = ST_FAIL;
                end
                default: begin
                    state_next = ST_RESET_HOLD;
                    tmr_next   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they register with the transition.
    always_comb begin
        npor_next     = (state_next == ST_TRAIN) || (state_next == ST_UP);
        app_rst_next  = (state_next != ST_UP);
        link_ok_next  = (state_next == ST_UP);
        width_ok_next = (state_next == ST_UP) && (lane_act_reg == LANES_5);
    end

    assign HIP_NPOR      = npor_reg;
    assign HIP_PIN_PERST = perst_f_reg;
    assign APP_RST       = app_rst_reg;
    assign LINK_OK       = link_ok_reg;
    assign WIDTH_OK      = width_ok_reg;
    assign RETRY_CNT     = retry_reg;
    assign LINK_DOWN_CNT = ldc_reg;
    assign STATE         = state_reg;

endmodule

// File: tb/tb_pcie_link_ctrl.sv
// Directed bench for pcie_link_ctrl with short timers: power-up, glitch,
// link-up/width, timeouts/FAIL, link drop, PERST priority and mid-run reset.
module tb_pcie_link_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        PCIE_PERST;
    logic        HIP_LINK_UP;
    logic [4:0]  HIP_LANE_ACT;
    logic        HIP_NPOR;
    logic        HIP_PIN_PERST;
    logic        APP_RST;
    logic        LINK_OK;
    logic        WIDTH_OK;
    logic [3:0]  RETRY_CNT;
    logic [15:0] LINK_DOWN_CNT;
    logic [2:0]  STATE;

    int n_checks = 0;
    int n_fail   = 0;

    pcie_link_ctrl #(
        .LANES           (8),
        .DEBOUNCE_CYC    (4),
        .NPOR_HOLD_CYC   (8),
        .LINK_TIMEOUT_CYC(100),
        .MAX_RETRY       (2)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .PCIE_PERST   (PCIE_PERST),
        .HIP_LINK_UP  (HIP_LINK_UP),
        .HIP_LANE_ACT (HIP_LANE_ACT),
        .HIP_NPOR     (HIP_NPOR),
        .HIP_PIN_PERST(HIP_PIN_PERST),
        .APP_RST      (APP_RST),
        .LINK_OK      (LINK_OK),
        .WIDTH_OK     (WIDTH_OK),
        .RETRY_CNT    (RETRY_CNT),
        .LINK_DOWN_CNT(LINK_DOWN_CNT),
        .STATE        (STATE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end else begin
            $display("ok   %s = 0x%0h", tag, obs);
        end
    endtask

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_vals(input string ph);
        check({ph, " STATE"},         32'(STATE),         32'd0);
        check({ph, " HIP_NPOR"},      32'(HIP_NPOR),      32'd0);
        check({ph, " HIP_PIN_PERST"}, 32'(HIP_PIN_PERST), 32'd0);
        check({ph, " APP_RST"},       32'(APP_RST),       32'd1);
        check({ph, " LINK_OK"},       32'(LINK_OK),       32'd0);
        check({ph, " WIDTH_OK"},      32'(WIDTH_OK),      32'd0);
        check({ph, " RETRY_CNT"},     32'(RETRY_CNT),     32'd0);
        check({ph, " LINK_DOWN_CNT"}, 32'(LINK_DOWN_CNT), 32'd0);
    endtask

    initial begin
        RST          = 1'b1;
        PCIE_PERST   = 1'b0;
        HIP_LINK_UP  = 1'b0;
        HIP_LANE_ACT = 5'd8;
        tick(5);
        check_reset_vals("por");
        RST = 1'b0;
        tick(2);

        // Glitch: 3 cycles high never reaches the 4-cycle debounce threshold.
        PCIE_PERST = 1'b1;
        tick(3);
        PCIE_PERST = 1'b0;
        tick(10);
        check("glitch HIP_PIN_PERST", 32'(HIP_PIN_PERST), 32'd0);
        check("glitch STATE",         32'(STATE),         32'd0);

        // Power-up: pin perst after 6 cycles, npor after a further 10.
        PCIE_PERST = 1'b1;
        tick(5);
        check("pwr pin_perst@5", 32'(HIP_PIN_PERST), 32'd0);
        tick(1);
        check("pwr pin_perst@6", 32'(HIP_PIN_PERST), 32'd1);
        check("pwr STATE@6",     32'(STATE),         32'd0);
        tick(9);
        check("pwr npor@15",     32'(HIP_NPOR),      32'd0);
        check("pwr STATE@15",    32'(STATE),         32'd1);
        tick(1);
        check("pwr npor@16",     32'(HIP_NPOR),      32'd1);
        check("pwr STATE@16",    32'(STATE),         32'd2);

        // First timeout after exactly 100 TRAIN cycles, then 8 cycles of npor low.
        tick(99);
        check("to1 STATE@99",    32'(STATE),     32'd2);
        check("to1 RETRY@99",    32'(RETRY_CNT), 32'd0);
        tick(1);
        check("to1 RETRY@100",   32'(RETRY_CNT), 32'd1);
        check("to1 STATE@100",   32'(STATE),     32'd1);
        check("to1 npor@100",    32'(HIP_NPOR),  32'd0);
        tick(7);
        check("to1 npor@107",    32'(HIP_NPOR),  32'd0);
        tick(1);
        check("to1 npor@108",    32'(HIP_NPOR),  32'd1);
        check("to1 STATE@108",   32'(STATE),     32'd2);

        // Link-up with matching width.
        HIP_LINK_UP = 1'b1;
        tick(2);
        check("lu LINK_OK@2",    32'(LINK_OK),   32'd0);
        tick(1);
        check("lu LINK_OK@3",    32'(LINK_OK),   32'd1);
        check("lu APP_RST@3",    32'(APP_RST),   32'd0);
        check("lu WIDTH_OK@3",   32'(WIDTH_OK),  32'd1);
        check("lu STATE@3",      32'(STATE),     32'd3);
        check("lu RETRY@3",      32'(RETRY_CNT), 32'd1);

        // Narrower negotiated width.
        HIP_LANE_ACT = 5'd4;
        tick(2);
        check("x4 WIDTH_OK",     32'(WIDTH_OK),  32'd0);
        check("x4 LINK_OK",      32'(LINK_OK),   32'd1);
        HIP_LANE_ACT = 5'd8;
        tick(2);
        check("x8 WIDTH_OK",     32'(WIDTH_OK),  32'd1);

        // Link drop and recovery, retry count untouched.
        HIP_LINK_UP = 1'b0;
        tick(2);
        check("drop LINK_OK@2",  32'(LINK_OK),       32'd1);
        tick(1);
        check("drop LINK_OK@3",  32'(LINK_OK),       32'd0);
        check("drop APP_RST@3",  32'(APP_RST),       32'd1);
        check("drop LDC@3",      32'(LINK_DOWN_CNT), 32'd1);
        check("drop STATE@3",    32'(STATE),         32'd2);
        check("drop RETRY@3",    32'(RETRY_CNT),     32'd1);
        HIP_LINK_UP = 1'b1;
        tick(3);
        check("reup STATE",      32'(STATE),     32'd3);
        check("reup LINK_OK",    32'(LINK_OK),   32'd1);
        check("reup RETRY",      32'(RETRY_CNT), 32'd1);

        // Second drop restarts the TRAIN timer from zero; second timeout -> FAIL.
        HIP_LINK_UP = 1'b0;
        tick(3);
        check("drop2 STATE",     32'(STATE),         32'd2);
        check("drop2 LDC",       32'(LINK_DOWN_CNT), 32'd2);
        tick(99);
        check("to2 STATE@99",    32'(STATE),     32'd2);
        tick(1);
        check("to2 RETRY@100",   32'(RETRY_CNT), 32'd2);
        check("to2 STATE@100",   32'(STATE),     32'd4);
        check("to2 npor@100",    32'(HIP_NPOR),  32'd0);
        tick(20);
        check("fail STATE held", 32'(STATE),     32'd4);
        check("fail npor held",  32'(HIP_NPOR),  32'd0);
        check("fail APP_RST",    32'(APP_RST),   32'd1);

        // PERST assertion leaves FAIL and clears the retry count.
        PCIE_PERST = 1'b0;
        tick(5);
        check("perst pin@5",     32'(HIP_PIN_PERST), 32'd1);
        tick(1);
        check("perst pin@6",     32'(HIP_PIN_PERST), 32'd0);
        check("perst STATE@6",   32'(STATE),         32'd4);
        check("perst RETRY@6",   32'(RETRY_CNT),     32'd2);
        tick(1);
        check("perst STATE@7",   32'(STATE),         32'd0);
        check("perst RETRY@7",   32'(RETRY_CNT),     32'd0);
        check("perst LDC kept",  32'(LINK_DOWN_CNT), 32'd2);

        // Priority: perst_f falls on the same edge lu_s rises.
        PCIE_PERST = 1'b1;
        tick(16);
        check("prio TRAIN STATE", 32'(STATE),    32'd2);
        check("prio TRAIN npor",  32'(HIP_NPOR), 32'd1);
        PCIE_PERST = 1'b0;
        tick(4);
        HIP_LINK_UP = 1'b1;
        tick(2);
        check("prio STATE@6",    32'(STATE),         32'd2);
        check("prio pin@6",      32'(HIP_PIN_PERST), 32'd0);
        tick(1);
        check("prio STATE@7",    32'(STATE),         32'd0);
        check("prio LINK_OK@7",  32'(LINK_OK),       32'd0);
        check("prio APP_RST@7",  32'(APP_RST),       32'd1);
        tick(1);
        check("prio STATE@8",    32'(STATE),         32'd0);

        // Reach UP, then RST mid-operation.
        PCIE_PERST = 1'b1;
        tick(17);
        check("pre-rst STATE",   32'(STATE),         32'd3);
        check("pre-rst LINK_OK", 32'(LINK_OK),       32'd1);
        check("pre-rst LDC",     32'(LINK_DOWN_CNT), 32'd2);
        RST = 1'b1;
        tick(1);
        check_reset_vals("rst");
        RST = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
